// File: rtl/ws2812_receiver.sv
// ws2812_receiver: decodes a WS2812 serial stream into frames of NUM_LED 24-bit pixels
module ws2812_receiver #(
    parameter int NUM_LED    = 8,
    parameter int T_MIN_HIGH = 20,
    parameter int T_THRESH   = 60,
    parameter int T_MAX_HIGH = 120,
    parameter int T_RESET    = 5000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  led_data,
    output logic [NUM_LED*24-1:0] rgb_data,
    output logic                  frame_valid,
    output logic                  frame_error,
    output logic                  busy
);
    localparam int NB   = NUM_LED * 24;
    localparam int CMAX = (T_RESET > T_MAX_HIGH + 1) ? T_RESET : T_MAX_HIGH + 1;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = $clog2(NB + 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_RST  = CW'(T_RESET);
    localparam logic [CW-1:0] C_RST1 = CW'(T_RESET - 1);
    localparam logic [CW-1:0] C_MIN  = CW'(T_MIN_HIGH);
    localparam logic [CW-1:0] C_THR  = CW'(T_THRESH);
    localparam logic [CW-1:0] C_MAX  = CW'(T_MAX_HIGH);
    localparam logic [CW-1:0] C_MAX1 = CW'(T_MAX_HIGH + 1);
    localparam logic [BW-1:0] B_FULL = BW'(NB);

    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

    state_t          state;
    logic            s0, s1;
    logic [CW-1:0]   high_cnt, low_cnt;
    logic [BW-1:0]   bit_cnt;
    logic            ovf;
    logic [NB-1:0]   sh;

    // edges are implied by the state: IDLE/LOW only see the line low, HIGH only high
    assign busy = (state == HIGH) || (state == LOW && bit_cnt != '0);

    // two-flop synchronizer for the asynchronous serial line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else begin
            s0 <= led_data;
            s1 <= s0;
        end
    end

    // pulse-width decoder, frame assembly and frame completion/abort
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= SYNC;
            high_cnt    <= '0;
            low_cnt     <= '0;
            bit_cnt     <= '0;
            ovf         <= 1'b0;
            sh          <= '0;
            rgb_data    <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                SYNC: begin
                    if (s1) begin
                        low_cnt <= '0;
                    end else if (low_cnt >= C_RST1) begin
                        low_cnt <= C_RST;
                        state   <= IDLE;
                    end else begin
                        low_cnt <= low_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (s1) begin
                        high_cnt <= C_ONE;
                        state    <= HIGH;
                    end
                end
                HIGH: begin
                    if (!s1) begin
                        low_cnt <= C_ONE;
                        if (high_cnt < C_MIN) begin
                            frame_error <= 1'b1;
                            bit_cnt     <= '0;
                            ovf         <= 1'b0;
                            sh          <= '0;
                            state       <= SYNC;
                        end else begin
                            state <= LOW;
                            if (bit_cnt != B_FULL) begin
                                sh      <= {sh[NB-2:0], high_cnt >= C_THR};
                                bit_cnt <= bit_cnt + 1'b1;
                            end else begin
                                ovf <= 1'b1;
                            end
                        end
                    end else if (high_cnt >= C_MAX) begin
                        high_cnt    <= C_MAX1;
                        frame_error <= 1'b1;
                        bit_cnt     <= '0;
                        ovf         <= 1'b0;
                        sh          <= '0;
                        low_cnt     <= '0;
                        state       <= SYNC;
                    end else begin
                        high_cnt <= high_cnt + 1'b1;
                    end
                end
                LOW: begin
                    if (s1) begin
                        high_cnt <= C_ONE;
                        state    <= HIGH;
                    end else if (low_cnt >= C_RST1) begin
                        low_cnt <= C_RST;
                        bit_cnt <= '0;
                        ovf     <= 1'b0;
                        state   <= IDLE;
                        if (bit_cnt == B_FULL && !ovf) begin
                            rgb_data    <= sh;
                            frame_valid <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end else begin
                        low_cnt <= low_cnt + 1'b1;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end
endmodule

// File: tb/tb_ws2812_receiver.sv
// tb_ws2812_receiver: randomized pulse-train bench with a frame-level reference model
module tb_ws2812_receiver;
    localparam int NUM_LED    = 2;
    localparam int T_MIN_HIGH = 20;
    localparam int T_THRESH   = 60;
    localparam int T_MAX_HIGH = 120;
    localparam int T_RESET    = 1000;
    localparam int NB         = NUM_LED * 24;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          led_data = 1'b0;
    logic [NB-1:0] rgb_data;
    logic          frame_valid, frame_error, busy;

    int checks = 0;
    int failures = 0;
    int tot_v = 0;
    int tot_e = 0;
    int tot_both = 0;
    int ws[$];
    logic [NB-1:0] m_rgb = '0;
    logic [7:0] pat = 8'hA5;

    ws2812_receiver #(
        .NUM_LED(NUM_LED), .T_MIN_HIGH(T_MIN_HIGH), .T_THRESH(T_THRESH),
        .T_MAX_HIGH(T_MAX_HIGH), .T_RESET(T_RESET)
    ) dut (
        .clk(clk), .reset_n(reset_n), .led_data(led_data), .rgb_data(rgb_data),
        .frame_valid(frame_valid), .frame_error(frame_error), .busy(busy)
    );

    always #5 clk = ~clk;

    // tally output pulses away from the active edge
    always @(negedge clk) begin
        if (frame_valid) tot_v++;
        if (frame_error) tot_e++;
        if (frame_valid && frame_error) tot_both++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic lvl, input int n);
        led_data = lvl;
        repeat (n) @(negedge clk);
    endtask

    function automatic int lowfor(input int w);
        return (125 - w >= 25) ? 125 - w : 25;
    endfunction

    function automatic int legal();
        return int'($urandom_range(T_MAX_HIGH, T_MIN_HIGH));
    endfunction

    // drive ws[] as high pulses, end with a long low, and compare against the frame model
    task automatic play(input string tag, input bit synced);
        int v0, e0, ev, ee;
        bit s;
        int bits[$];
        v0 = tot_v;
        e0 = tot_e;
        ev = 0;
        ee = 0;
        s = synced;
        foreach (ws[i]) begin
            hold(1'b1, ws[i]);
            if (i == 0) begin
                hold(1'b0, 10);
                check({tag, "_busy_mid"}, busy, s && ws[0] >= T_MIN_HIGH && ws[0] <= T_MAX_HIGH);
                hold(1'b0, lowfor(ws[i]) - 10);
            end else begin
                hold(1'b0, lowfor(ws[i]));
            end
            if (s) begin
                if (ws[i] < T_MIN_HIGH || ws[i] > T_MAX_HIGH) begin
                    ee++;
                    s = 1'b0;
                end else begin
                    bits.push_back(ws[i] >= T_THRESH ? 1 : 0);
                end
            end
        end
        hold(1'b0, T_RESET + 20);
        if (s && bits.size() == NB) begin
            ev = 1;
            foreach (bits[i]) m_rgb[NB-1-i] = (bits[i] != 0);
        end else if (s && bits.size() > 0) begin
            ee++;
        end
        check({tag, "_valid"}, tot_v - v0, ev);
        check({tag, "_error"}, tot_e - e0, ee);
        check({tag, "_rgb"}, rgb_data, m_rgb);
        check({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rgb", rgb_data, 0);
        check("rst_valid", frame_valid, 0);
        check("rst_error", frame_error, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        ws = {};
        play("sync", 1'b0);

        ws = {};
        for (int i = 0; i < NB; i++) ws.push_back(pat[7 - i % 8] ? 80 : 40);
        play("good", 1'b1);
        check("good_const", rgb_data, {NUM_LED*3{8'hA5}});

        ws = {};
        for (int i = 0; i < NB / 2; i++) ws.push_back(legal());
        play("short", 1'b1);

        ws = {};
        for (int i = 0; i < NB + 2; i++) ws.push_back(legal());
        play("overflow", 1'b1);

        ws = {};
        for (int i = 0; i < 20; i++) ws.push_back(legal());
        ws.push_back(10);
        for (int i = 0; i < 20; i++) ws.push_back(legal());
        play("glitch", 1'b1);

        ws = {200};
        play("stuck", 1'b1);

        ws = {59, 60, 20, 120};
        for (int i = 4; i < NB; i++) ws.push_back(legal());
        play("thresh", 1'b1);

        ws = {};
        for (int i = 0; i < 10; i++) ws.push_back(legal());
        ws.push_back(19);
        for (int i = 0; i < 10; i++) ws.push_back(legal());
        play("w19", 1'b1);

        ws = {};
        for (int i = 0; i < 10; i++) ws.push_back(legal());
        ws.push_back(121);
        for (int i = 0; i < 10; i++) ws.push_back(legal());
        play("w121", 1'b1);

        begin
            int v0, e0;
            v0 = tot_v;
            e0 = tot_e;
            for (int i = 0; i < 20; i++) begin
                int w;
                w = legal();
                hold(1'b1, w);
                hold(1'b0, lowfor(w));
            end
            reset_n = 1'b0;
            hold(1'b0, 3);
            check("midrst_rgb", rgb_data, 0);
            check("midrst_busy", busy, 0);
            check("midrst_pulses", (tot_v - v0) + (tot_e - e0), 0);
            m_rgb = '0;
            reset_n = 1'b1;
        end
        ws = {};
        for (int i = 0; i < 20; i++) ws.push_back(legal());
        play("inflight", 1'b0);

        for (int f = 0; f < 3; f++) begin
            ws = {};
            for (int i = 0; i < NB; i++) ws.push_back(legal());
            play($sformatf("rand%0d", f), 1'b1);
        end

        check("exclusive", tot_both, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
